// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational 32-bit ALU between two requesters
//   (0 = execute stage, 1 = address/branch helper) using a three-state
//   IDLE -> EXEC -> RESP sequencer with round-robin tie breaking.
//
// Parameters
//   FIRST_PRIO   requester that wins the first tie after reset
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake (ready only in IDLE)
//   reqN_control/src1/src2         one-hot op and operands
//   rspN_valid / rspN_ready        response handshake
//   rspN_result / rspN_err         registered result and op-error flag
//   alu_control/src1/src2          registered drive to the shared ALU
//   alu_result                     combinational result from the ALU
//
// Build option
//   ALU_ONEHOT_CHK_EN  when defined, a non-one-hot control is suppressed
//                      (ALU sees control 0) and answered with result 0 and
//                      err=1. When undefined, control passes through and
//                      rspN_err is tied to 0.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_control,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_control,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_err,

  output logic [15:0] alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        gnt_q;
  logic        rsp_valid_q;
  logic [15:0] alu_control_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [31:0] result_q;

  logic        grant;
  logic        accept;
  logic [15:0] sel_control;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;
  logic        sel_bad;
  logic        rsp_taken;

`ifdef ALU_ONEHOT_CHK_EN
  logic        bad_q;
  logic        err_q;

  function automatic logic is_onehot(input logic [15:0] c);
    return (c != '0) && ((c & (c - 16'd1)) == '0);
  endfunction
`endif

  // Grant: lone valid requester wins; on a tie, the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    accept      = (state == S_IDLE) && (req0_valid || req1_valid);
    req0_ready  = accept && !grant;
    req1_ready  = accept && grant;
    sel_control = grant ? req1_control : req0_control;
    sel_src1    = grant ? req1_src1    : req0_src1;
    sel_src2    = grant ? req1_src2    : req0_src2;
`ifdef ALU_ONEHOT_CHK_EN
    sel_bad     = !is_onehot(sel_control);
`else
    sel_bad     = 1'b0;
`endif
    // Only the granted requester's rsp_ready can complete the response.
    rsp_taken   = gnt_q ? rsp1_ready : rsp0_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      last_grant    <= ~FIRST_PRIO;
      gnt_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      alu_control_q <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      result_q      <= '0;
`ifdef ALU_ONEHOT_CHK_EN
      bad_q         <= 1'b0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // The control register doubles as the ALU drive: it is loaded
            // here so it is live exactly during EXEC and cleared on leaving.
            alu_control_q <= sel_bad ? '0 : sel_control;
            src1_q        <= sel_src1;
            src2_q        <= sel_src2;
            gnt_q         <= grant;
`ifdef ALU_ONEHOT_CHK_EN
            bad_q         <= sel_bad;
`endif
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q      <= sel_bad_exec() ? '0 : alu_result;
`ifdef ALU_ONEHOT_CHK_EN
          err_q         <= bad_q;
`endif
          alu_control_q <= '0;
          rsp_valid_q   <= 1'b1;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (rsp_taken) begin
            rsp_valid_q <= 1'b0;
            last_grant  <= gnt_q;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic sel_bad_exec();
`ifdef ALU_ONEHOT_CHK_EN
    return bad_q;
`else
    return 1'b0;
`endif
  endfunction

  assign alu_control = alu_control_q;
  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;

  assign rsp0_valid  = rsp_valid_q && !gnt_q;
  assign rsp1_valid  = rsp_valid_q && gnt_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;

`ifdef ALU_ONEHOT_CHK_EN
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;
`else
  assign rsp0_err    = 1'b0;
  assign rsp1_err    = 1'b0;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU instance between two requesters: requester 0 is the execute stage and requester 1 is the address/branch helper.
- Uses a three-state sequencer with round-robin arbitration.
- Each requester has its own valid/ready request and response handshakes.
- Drives the ALU's one-hot 16-bit control bus and operands from registers, and captures the ALU result into a response register.

Parameters:
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_control  in  16  one-hot ALU op (bit11 add, bit10 sub, bit9 slt, bit8 sltu, bit7 and, bit6 nor, bit5 or, bit4 xor, bit3 sll, bit2 srl, bit1 sra, bit0 lui, bit12 sht, bit13 shtu, bit14 nand, bit15 lli)
- req0_src1  in  32  operand 1 (shift amount in [4:0] for shifts)
- req0_src2  in  32  operand 2
- rsp0_valid  out  1  result valid for requester 0
- rsp0_ready  in  1  requester 0 takes result
- rsp0_result  out  32  result
- rsp0_err  out  1  op error flag (see Optional Feature)
- req1_* / rsp1_*  same set and widths as requester 0
- alu_control  out  16  to shared ALU
- alu_src1  out  32  to shared ALU
- alu_src2  out  32  to shared ALU
- alu_result  in  32  from shared ALU (combinational)

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, and the operand/control/result registers are 0.
  - Round-robin pointer last_grant = ~FIRST_PRIO.
- Reset mid-operation abandons the operation. No response is ever issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = the single valid requester. If both are valid, grant = ~last_grant.
  - reqN_ready = 1 combinationally for the granted N only, and only in IDLE. At most one ready per cycle.
  - On accept (valid & ready): latch control/src1/src2 and the granted id into registers, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (one cycle):
  - alu_control, alu_src1 and alu_src2 are driven from the latched registers.
  - At the edge, capture alu_result into the result register, then go to RESP.
- Outside EXEC, alu_control = 16'h0000. alu_src1/alu_src2 hold their last latched values.
- RESP:
  - rspN_valid = 1 for the granted N only. rspN_result and rspN_err come from registers and are stable while valid.
  - Hold until rspN_ready=1. On that edge: last_grant = N, deassert valid, return to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- Latency: accept at edge T; rsp_valid is high in cycle T+2.
- Minimum spacing is 3 cycles per operation with rsp_ready held at 1.
- Requests are never dropped: an ungranted valid request waits in IDLE.
- Requesters must hold valid and operands stable until ready; the arbiter does not check this.
- rsp_ready of the non-granted requester is ignored.
- Width rules: the result is the ALU's full 32 bits. The arbiter performs no arithmetic.

Optional Feature:
- Macro ALU_ONEHOT_CHK_EN.
- Defined:
  - On accept, if the latched control is not exactly one-hot (zero or multi-hot), EXEC drives alu_control=0.
  - The response then returns result 32'h0 with rspN_err=1.
  - The handshake and timing are unchanged.
- Undefined:
  - The control is passed through unchecked. The result follows the ALU's own priority among multi-hot bits.
  - rsp0_err and rsp1_err are tied to 0.

Test Plan:
- Single add: req0 control=16'h0800, src1=5, src2=7, rsp0_ready=1 -> req0_ready in the accept cycle, rsp0_valid two cycles later, rsp0_result=32'd12, rsp0_err=0.
- Tie and round-robin: both valid continuously, req0 sub 16'h0400 10-3, req1 sll 16'h0008 src1=4 src2=1, FIRST_PRIO=0 -> grants alternate 0,1,0,1; results 7 and 16; never two readies in one cycle.
- Backpressure: req1 lui 16'h0001 src2=32'h0000ABCD, rsp1_ready low for 5 cycles -> rsp1_valid held with result 32'hABCD0000 stable; req0_ready stays 0 throughout.
- Slt signed: src1=32'hFFFFFFFF, src2=1, control 16'h0200 -> result 32'd1; same operands with sltu 16'h0100 -> 32'd0.
- Reset mid-EXEC: assert rst in the EXEC cycle -> next cycle state is IDLE, all rsp_valid=0, alu_control=0, and no response for the aborted op.
- Onehot check (ALU_ONEHOT_CHK_EN defined): control=16'h0C00 -> result 32'h0, rsp_err=1; undefined -> result equals the add result and rsp_err=0.
